// File: rtl/ring_serial_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ring_serial_loader: parallel-to-serial feeder for the rotating ring      |
// | register. Optional abort path enabled by RING_LOADER_ABORT_EN.           |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module ring_serial_loader #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             clr,
`ifdef RING_LOADER_ABORT_EN
  input  logic             abort,
  output logic             aborted,
`endif
  input  logic             start,
  input  logic [WIDTH-1:0] word_in,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic             load,
  output logic             serial_data
);

  localparam int c_cnt_w = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [c_cnt_w-1:0]  r_cnt;
  logic [WIDTH-1:0]    r_sreg;
  logic                r_load;
  logic                r_serial;
  logic                w_accept;
  logic                w_last;
  logic                w_abort;
  logic [WIDTH-1:0]    w_seq;

  // Transmit order: w[WIDTH-2] down to w[0], then w[WIDTH-1] last.
  assign w_seq = {word_in[WIDTH-2:0], word_in[WIDTH-1]};

`ifdef RING_LOADER_ABORT_EN
  logic r_aborted;
  assign w_abort = abort && (r_state == S_SHIFT);
  assign aborted = r_aborted;
`else
  assign w_abort = 1'b0;
`endif

  assign ready       = (r_state == S_IDLE) || (r_state == S_DONE);
  assign busy        = (r_state == S_SHIFT);
  assign done        = (r_state == S_DONE);
  assign load        = r_load;
  assign serial_data = r_serial;
  assign w_accept    = ready && start;
  assign w_last      = (r_state == S_SHIFT) && (r_cnt == c_last);

  always_ff @(posedge clk) begin
    if (clr) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next_state = S_SHIFT;
      S_SHIFT: begin
        if (w_abort)     w_next_state = S_IDLE;
        else if (w_last) w_next_state = S_DONE;
      end
      S_DONE:  w_next_state = start ? S_SHIFT : S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      r_cnt    <= '0;
      r_sreg   <= '0;
      r_load   <= 1'b0;
      r_serial <= 1'b0;
    end else if (w_abort) begin
      r_load   <= 1'b0;
      r_serial <= 1'b0;
    end else if (w_accept) begin
      // First bit is presented now so the ring samples it on the next edge.
      r_sreg   <= w_seq << 1;
      r_serial <= w_seq[WIDTH-1];
      r_load   <= 1'b1;
      r_cnt    <= '0;
    end else if (r_state == S_SHIFT) begin
      if (w_last) begin
        r_load   <= 1'b0;
        r_serial <= 1'b0;
      end else begin
        r_serial <= r_sreg[WIDTH-1];
        r_sreg   <= r_sreg << 1;
        r_cnt    <= r_cnt + 1'b1;
      end
    end
  end

`ifdef RING_LOADER_ABORT_EN
  always_ff @(posedge clk) begin
    if (clr) begin
      r_aborted <= 1'b0;
    end else begin
      r_aborted <= w_abort;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_ring_serial_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_ring_serial_loader: directed bench driving a behavioural ring model.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_ring_serial_loader;

  localparam int W = 6;

  logic         clk = 1'b0;
  logic         clr = 1'b1;
  logic         ring_clr = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] word_in = '0;
  logic         ready, busy, done, load, serial_data;
  logic [W-1:0] number;
  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] exp_bits;
`ifdef RING_LOADER_ABORT_EN
  logic         abort = 1'b0;
  logic         aborted;
`endif

  always #5 clk = ~clk;

  ring_serial_loader #(.WIDTH(W)) dut (
    .clk         (clk),
    .clr         (clr),
`ifdef RING_LOADER_ABORT_EN
    .abort       (abort),
    .aborted     (aborted),
`endif
    .start       (start),
    .word_in     (word_in),
    .ready       (ready),
    .busy        (busy),
    .done        (done),
    .load        (load),
    .serial_data (serial_data)
  );

  // Ring in load mode: new bit into the top, old top wraps to bit 0.
  always_ff @(posedge clk) begin
    if (ring_clr)  number <= '0;
    else if (load) number <= {serial_data, number[W-3:0], number[W-1]};
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset
    tick;
    clr = 1'b0;
    ring_clr = 1'b0;
    chk("rst_ready", 8'(ready), 8'd1);
    chk("rst_busy", 8'(busy), 8'd0);
    chk("rst_done", 8'(done), 8'd0);
    chk("rst_load", 8'(load), 8'd0);
    chk("rst_serial", 8'(serial_data), 8'd0);

    // Single transfer of 101100: serial sequence 0,1,1,0,0,1
    start = 1'b1;
    word_in = 6'b101100;
    tick;
    start = 1'b0;
    exp_bits = 6'b011001;
    chk("t1_ready_e0", 8'(ready), 8'd0);
    chk("t1_busy_e0", 8'(busy), 8'd1);
    for (int k = 0; k < W; k++) begin
      if (k != 0) tick;
      chk("t1_load", 8'(load), 8'd1);
      chk("t1_serial", 8'(serial_data), 8'(exp_bits[W-1-k]));
      chk("t1_done_low", 8'(done), 8'd0);
    end
    tick;
    chk("t1_done", 8'(done), 8'd1);
    chk("t1_ready_done", 8'(ready), 8'd1);
    chk("t1_load_off", 8'(load), 8'd0);
    chk("t1_serial_off", 8'(serial_data), 8'd0);
    chk("t1_ring", 8'(number), 8'b00101100);
    tick;
    chk("t1_done_pulse", 8'(done), 8'd0);
    chk("t1_idle_ready", 8'(ready), 8'd1);
    chk("t1_idle_busy", 8'(busy), 8'd0);

    // start held high; word changes after acceptance; chained accept in DONE
    start = 1'b1;
    word_in = 6'b000001;
    tick;
    word_in = 6'b111110;
    exp_bits = 6'b000010;
    for (int k = 0; k < W; k++) begin
      if (k != 0) tick;
      chk("t2a_load", 8'(load), 8'd1);
      chk("t2a_serial", 8'(serial_data), 8'(exp_bits[W-1-k]));
    end
    tick;
    chk("t2_done_a", 8'(done), 8'd1);
    chk("t2_ring_a", 8'(number), 8'b00000001);
    tick;
    start = 1'b0;
    chk("t2_accept_in_done", 8'(busy), 8'd1);
    chk("t2_done_clear", 8'(done), 8'd0);
    exp_bits = 6'b111101;
    for (int k = 0; k < W; k++) begin
      if (k != 0) tick;
      chk("t2b_load", 8'(load), 8'd1);
      chk("t2b_serial", 8'(serial_data), 8'(exp_bits[W-1-k]));
    end
    tick;
    chk("t2_done_b", 8'(done), 8'd1);
    chk("t2_ring_b", 8'(number), 8'b00111110);
    tick;
    chk("t2_idle", 8'(ready), 8'd1);

    // start during 3rd load cycle is ignored
    start = 1'b1;
    word_in = 6'b010011;
    tick;
    start = 1'b0;
    tick;
    tick;
    start = 1'b1;
    word_in = 6'b111111;
    tick;
    start = 1'b0;
    chk("t3_still_busy", 8'(busy), 8'd1);
    tick;
    tick;
    chk("t3_no_early_done", 8'(done), 8'd0);
    tick;
    chk("t3_done", 8'(done), 8'd1);
    chk("t3_ring", 8'(number), 8'b00010011);
    for (int k = 0; k < 3; k++) begin
      tick;
      chk("t3_single_done", 8'(done), 8'd0);
      chk("t3_no_reload", 8'(load), 8'd0);
    end

    // clr during 4th load cycle
    start = 1'b1;
    word_in = 6'b110011;
    tick;
    start = 1'b0;
    tick;
    tick;
    tick;
    clr = 1'b1;
    tick;
    clr = 1'b0;
    chk("t4_load", 8'(load), 8'd0);
    chk("t4_busy", 8'(busy), 8'd0);
    chk("t4_ready", 8'(ready), 8'd1);
    chk("t4_done", 8'(done), 8'd0);
    for (int k = 0; k < 4; k++) begin
      tick;
      chk("t4_no_done", 8'(done), 8'd0);
    end

`ifdef RING_LOADER_ABORT_EN
    // abort during 2nd load cycle, then a clean transfer
    start = 1'b1;
    word_in = 6'b111000;
    tick;
    start = 1'b0;
    tick;
    abort = 1'b1;
    tick;
    abort = 1'b0;
    chk("t5_aborted", 8'(aborted), 8'd1);
    chk("t5_done", 8'(done), 8'd0);
    chk("t5_load", 8'(load), 8'd0);
    chk("t5_ready", 8'(ready), 8'd1);
    tick;
    chk("t5_aborted_pulse", 8'(aborted), 8'd0);
    start = 1'b1;
    word_in = 6'b010101;
    tick;
    start = 1'b0;
    exp_bits = 6'b101010;
    for (int k = 0; k < W; k++) begin
      if (k != 0) tick;
      chk("t5_serial", 8'(serial_data), 8'(exp_bits[W-1-k]));
    end
    tick;
    chk("t5_done_after", 8'(done), 8'd1);
    chk("t5_ring", 8'(number), 8'b00010101);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
